// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master widths, alignment mask and FSM state encoding.
package apb_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [1:0] APB_ALIGN_MASK = 2'b11;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS cycles and flags expiry at TIMEOUT-1; TIMEOUT=0 never expires.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] count;
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (en) count <= count + CW'(1);
    end
    assign expired = (TIMEOUT != 0) && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3 master turning a command stream into
// SETUP/ACCESS transfers and returning data/status on a response stream.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              I_PCLK,
    input  logic              I_PRESET,
    input  logic              I_CMD_VALID,
    output logic              O_CMD_READY,
    input  logic              I_CMD_WRITE,
    input  logic [ADDR_W-1:0] I_CMD_ADDR,
    input  logic [DATA_W-1:0] I_CMD_WDATA,
    output logic              O_RSP_VALID,
    input  logic              I_RSP_READY,
    output logic [DATA_W-1:0] O_RSP_RDATA,
    output logic              O_RSP_ERR,
    output logic              O_PSEL,
    output logic              O_PENABLE,
    output logic              O_PWRITE,
    output logic [ADDR_W-1:0] O_PADDR,
    output logic [DATA_W-1:0] O_PWDATA,
    input  logic [DATA_W-1:0] I_PRDATA,
    input  logic              I_PREADY
);
    apb_state_t state, nxt;
    logic accept, misaligned, expired;
    assign accept     = O_CMD_READY && I_CMD_VALID;
    assign misaligned = (I_CMD_ADDR[1:0] & APB_ALIGN_MASK) != 2'b00;
    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(I_PCLK),
        .rst(I_PRESET),
        .clr(state != ACCESS),
        .en(state == ACCESS),
        .expired(expired)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? (misaligned ? RESP : SETUP) : IDLE;
            SETUP:   nxt = ACCESS;
            ACCESS:  nxt = (I_PREADY || expired) ? RESP : ACCESS;
            RESP:    nxt = I_RSP_READY ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end
    // Handshake/select outputs are registered from the next state so they line up with it.
    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            state       <= IDLE;
            O_CMD_READY <= 1'b0;
            O_RSP_VALID <= 1'b0;
            O_RSP_RDATA <= '0;
            O_RSP_ERR   <= 1'b0;
            O_PSEL      <= 1'b0;
            O_PENABLE   <= 1'b0;
            O_PWRITE    <= 1'b0;
            O_PADDR     <= '0;
            O_PWDATA    <= '0;
        end else begin
            state       <= nxt;
            O_CMD_READY <= nxt == IDLE;
            O_PSEL      <= nxt == SETUP || nxt == ACCESS;
            O_PENABLE   <= nxt == ACCESS;
            O_RSP_VALID <= nxt == RESP;
            if (accept) begin
                O_PWRITE <= I_CMD_WRITE;
                O_PADDR  <= I_CMD_ADDR;
                O_PWDATA <= I_CMD_WDATA;
            end
            if (accept && misaligned) begin
                O_RSP_RDATA <= '0;
                O_RSP_ERR   <= 1'b1;
            end else if (state == ACCESS && I_PREADY) begin
                O_RSP_RDATA <= O_PWRITE ? '0 : I_PRDATA;
                O_RSP_ERR   <= 1'b0;
            end else if (state == ACCESS && expired) begin
                O_RSP_RDATA <= '0;
                O_RSP_ERR   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and randomized transfers against a PREADY-programmable
// slave, checked against a transaction-level response/latency model.
module tb_apb_master_bridge;
    localparam int TO = 16;
    logic        I_PCLK = 1'b0;
    logic        I_PRESET = 1'b1;
    logic        I_CMD_VALID = 1'b0;
    logic        O_CMD_READY;
    logic        I_CMD_WRITE = 1'b0;
    logic [31:0] I_CMD_ADDR = '0;
    logic [31:0] I_CMD_WDATA = '0;
    logic        O_RSP_VALID;
    logic        I_RSP_READY = 1'b0;
    logic [31:0] O_RSP_RDATA;
    logic        O_RSP_ERR;
    logic        O_PSEL;
    logic        O_PENABLE;
    logic        O_PWRITE;
    logic [31:0] O_PADDR;
    logic [31:0] O_PWDATA;
    logic [31:0] I_PRDATA = '0;
    logic        I_PREADY = 1'b0;
    int checks = 0;
    int failures = 0;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .I_PCLK(I_PCLK), .I_PRESET(I_PRESET),
        .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY), .I_CMD_WRITE(I_CMD_WRITE),
        .I_CMD_ADDR(I_CMD_ADDR), .I_CMD_WDATA(I_CMD_WDATA),
        .O_RSP_VALID(O_RSP_VALID), .I_RSP_READY(I_RSP_READY), .O_RSP_RDATA(O_RSP_RDATA),
        .O_RSP_ERR(O_RSP_ERR), .O_PSEL(O_PSEL), .O_PENABLE(O_PENABLE), .O_PWRITE(O_PWRITE),
        .O_PADDR(O_PADDR), .O_PWDATA(O_PWDATA), .I_PRDATA(I_PRDATA), .I_PREADY(I_PREADY)
    );

    always #5 I_PCLK = ~I_PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response, number of ACCESS cycles and accept-to-RSP_VALID latency from the protocol rules.
    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] rd, input int wt,
                         output bit e_err, output logic [31:0] e_rd, output int e_acc, output int e_lat);
        if (a % 4 != 0) begin
            e_err = 1; e_rd = 0; e_acc = 0; e_lat = 1;
        end else if (wt < TO) begin
            e_err = 0; e_rd = w ? 32'd0 : rd; e_acc = wt + 1; e_lat = e_acc + 2;
        end else begin
            e_err = 1; e_rd = 0; e_acc = TO; e_lat = TO + 2;
        end
    endtask

    // Runs one transfer; slave raises PREADY on ACCESS cycle index wt. Called at a negedge.
    task automatic do_txn(input string tag, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int wt, input int hold);
        bit e_err, bad, busy, hold_bad;
        logic [31:0] e_rd, held;
        int e_acc, e_lat, lat, psel_n, pen_n, acc, waitc;
        model(w, a, rd, wt, e_err, e_rd, e_acc, e_lat);
        waitc = 0;
        while (!O_CMD_READY && waitc < 8) begin
            @(negedge I_PCLK);
            waitc++;
        end
        chk({tag, "_cmd_ready"}, O_CMD_READY, 1'b1);
        I_CMD_VALID = 1; I_CMD_WRITE = w; I_CMD_ADDR = a; I_CMD_WDATA = d;
        @(posedge I_PCLK);
        @(negedge I_PCLK);
        I_CMD_VALID = 0;
        lat = 0; psel_n = 0; pen_n = 0; acc = 0; bad = 0; busy = 0;
        for (int c = 1; c <= 40; c++) begin
            if (O_RSP_VALID) begin
                lat = c;
                break;
            end
            busy |= O_CMD_READY;
            if (O_PSEL) begin
                psel_n++;
                if (O_PADDR !== a || O_PWRITE !== w || (w && O_PWDATA !== d)) bad = 1;
            end
            if (O_PENABLE) pen_n++;
            if (O_PSEL && O_PENABLE) begin
                I_PREADY = (acc == wt);
                I_PRDATA = (acc == wt) ? rd : $urandom;
                acc++;
            end else begin
                I_PREADY = 1'($urandom_range(0, 1));
                I_PRDATA = $urandom;
            end
            @(negedge I_PCLK);
        end
        I_PREADY = 0;
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_err"}, O_RSP_ERR, e_err);
        chk({tag, "_rdata"}, O_RSP_RDATA, e_rd);
        chk({tag, "_psel_cycles"}, psel_n, (a % 4 != 0) ? 0 : e_acc + 1);
        chk({tag, "_penable_cycles"}, pen_n, e_acc);
        chk({tag, "_bus_stable"}, bad, 1'b0);
        chk({tag, "_busy_cmd_ready"}, busy, 1'b0);
        held = O_RSP_RDATA;
        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            I_CMD_VALID = 1; I_CMD_ADDR = $urandom & 32'hFC;
            @(negedge I_PCLK);
            if (!O_RSP_VALID || O_RSP_RDATA !== held || O_RSP_ERR !== e_err || O_CMD_READY || O_PSEL)
                hold_bad = 1;
        end
        if (hold > 0) chk({tag, "_rsp_hold"}, hold_bad, 1'b0);
        I_CMD_VALID = 0;
        I_RSP_READY = 1;
        @(negedge I_PCLK);
        I_RSP_READY = 0;
        chk({tag, "_rsp_done"}, {O_RSP_VALID, O_CMD_READY, O_PSEL}, 3'b010);
    endtask

    initial begin
        int waitc;
        repeat (3) @(negedge I_PCLK);
        chk("reset_outputs", {O_CMD_READY, O_RSP_VALID, O_PSEL, O_PENABLE, O_PWRITE, O_RSP_ERR}, 6'b0);
        chk("reset_paddr", O_PADDR, 32'd0);
        chk("reset_rdata", O_RSP_RDATA, 32'd0);
        I_PRESET = 0;
        @(negedge I_PCLK);
        chk("post_reset_cmd_ready", O_CMD_READY, 1'b1);
        do_txn("wr500", 1, 32'h4, 32'd500, 32'h0, 0, 0);
        chk("wr500_pwdata", O_PWDATA, 32'd500);
        do_txn("rd_wait3", 0, 32'h4, 32'h0, 32'h1F4, 3, 0);
        do_txn("rd_timeout", 0, 32'h8, 32'h0, 32'hDEAD, 1000, 0);
        do_txn("after_timeout", 0, 32'hC, 32'h0, 32'h1234, 1, 0);
        do_txn("wr_misaligned", 1, 32'h6, 32'h55, 32'h0, 0, 0);
        do_txn("rsp_hold5", 0, 32'h10, 32'h0, 32'hCAFE, 2, 5);
        do_txn("rd_wait15", 0, 32'h14, 32'h0, 32'h7777, TO - 1, 0);
        for (int i = 0; i < 25; i++) begin
            logic [31:0] a;
            a = {24'd0, 8'($urandom)};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_txn("rand", 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                   $urandom_range(0, 20), $urandom_range(0, 3));
        end
        waitc = 0;
        while (!O_CMD_READY && waitc < 8) begin
            @(negedge I_PCLK);
            waitc++;
        end
        I_CMD_VALID = 1; I_CMD_WRITE = 0; I_CMD_ADDR = 32'h20;
        @(posedge I_PCLK);
        @(negedge I_PCLK);
        I_CMD_VALID = 0;
        I_PREADY = 0;
        repeat (3) @(negedge I_PCLK);
        chk("mid_access", {O_PSEL, O_PENABLE}, 2'b11);
        I_PRESET = 1;
        @(negedge I_PCLK);
        chk("reset_mid_xfer", {O_PSEL, O_PENABLE, O_RSP_VALID, O_CMD_READY}, 4'b0);
        chk("reset_mid_paddr", O_PADDR, 32'd0);
        I_PRESET = 0;
        @(negedge I_PCLK);
        chk("after_reset_cmd_ready", O_CMD_READY, 1'b1);
        do_txn("wr_after_reset", 1, 32'h24, 32'hA5A5A5A5, 32'h0, 1, 0);
        chk("wr_after_reset_pwdata", O_PWDATA, 32'hA5A5A5A5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
